// File: rtl/limn2600_defs.sv
// rtl/limn2600_defs.sv - shared FSM states, port IDs and grant helper for the memory arbiter
package limn2600_defs;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  function automatic logic [1:0] port_mask(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/limn2600_rr_arb2.sv
// rtl/limn2600_rr_arb2.sv - two-requester round-robin arbiter, one-hot grant
module limn2600_rr_arb2
  import limn2600_defs::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_accept,
  output logic [1:0] o_gnt
);

  logic r_last;

  // On a tie the port that did not win last time gets the grant.
  always_comb begin
    o_gnt = i_req;
    if (i_req == 2'b11) begin
      o_gnt = port_mask(~r_last);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last <= PORT_D;
    end else if (i_accept) begin
      r_last <= (o_gnt == port_mask(PORT_D)) ? PORT_D : PORT_I;
    end
  end

endmodule

// File: rtl/limn2600_mem_arbiter.sv
// rtl/limn2600_mem_arbiter.sv - fetch/data port arbiter onto a single-transaction SRAM bus with timeout
module limn2600_mem_arbiter
  import limn2600_defs::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [31:0]           i_addr,
  output logic                  i_done,
  output logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [31:0]           d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_done,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  err,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic [31:0]           mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_rdy,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t                r_state;
  logic                  r_port;
  logic                  r_we;
  logic [31:0]           r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [CW-1:0]         r_cnt;
  logic                  r_mem_cs;
  logic                  r_mem_we;
  logic                  r_i_done;
  logic                  r_d_done;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_i_rdata;
  logic [DATA_WIDTH-1:0] r_d_rdata;

  logic [1:0]            w_mask;
  logic [1:0]            w_elig;
  logic [1:0]            w_gnt;
  logic                  w_accept;
  logic                  w_sel_d;
  logic                  w_finish;
  logic [DATA_WIDTH-1:0] w_rdata_cap;

  // The port whose done is pulsing right now may not re-win in the same cycle.
  assign w_mask      = (r_i_done | r_d_done) ? port_mask(r_port) : 2'b00;
  assign w_elig      = {d_req, i_req} & ~w_mask;
  assign w_accept    = (r_state == ST_IDLE) && (w_elig != 2'b00);
  assign w_sel_d     = (w_gnt == port_mask(PORT_D));
  assign w_finish    = mem_rdy || (r_cnt == CW'(TIMEOUT - 1));
  assign w_rdata_cap = (mem_rdy && !r_we) ? mem_rdata : '0;

  limn2600_rr_arb2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .i_req    (w_elig),
    .i_accept (w_accept),
    .o_gnt    (w_gnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_port    <= PORT_I;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_cnt     <= '0;
      r_mem_cs  <= 1'b0;
      r_mem_we  <= 1'b0;
      r_i_done  <= 1'b0;
      r_d_done  <= 1'b0;
      r_err     <= 1'b0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      r_mem_cs  <= 1'b0;
      r_mem_we  <= 1'b0;
      r_i_done  <= 1'b0;
      r_d_done  <= 1'b0;
      r_err     <= 1'b0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_port   <= w_sel_d ? PORT_D : PORT_I;
            r_we     <= w_sel_d & d_we;
            r_addr   <= w_sel_d ? d_addr : i_addr;
            r_wdata  <= w_sel_d ? d_wdata : '0;
            r_mem_cs <= 1'b1;
            r_mem_we <= w_sel_d & d_we;
            r_state  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_cnt   <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          // A timeout completes like a normal access but with err set and zero data.
          if (w_finish) begin
            r_state <= ST_IDLE;
            r_err   <= ~mem_rdy;
            if (r_port == PORT_D) begin
              r_d_done  <= 1'b1;
              r_d_rdata <= w_rdata_cap;
            end else begin
              r_i_done  <= 1'b1;
              r_i_rdata <= w_rdata_cap;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mem_cs    = r_mem_cs;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign i_done    = r_i_done;
  assign d_done    = r_d_done;
  assign err       = r_err;
  assign i_rdata   = r_i_rdata;
  assign d_rdata   = r_d_rdata;

endmodule
